// File: rtl/adc_acq_controller.sv
// Conversion sequencer for the SPI ADC: issues periodic triggers for a run and
// arbitrates ADC access between conversions and PS register-access words.
module adc_acq_controller #(
    parameter int CNT_WIDTH    = 32,
    parameter int MIN_PERIOD   = 40,
    parameter int GUARD_CYCLES = 64
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [CNT_WIDTH-1:0] cfg_num_samples,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 adc_busy,
    output logic                 trigger,
    input  logic [31:0]          s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 sts_running,
    output logic                 sts_done,
    output logic                 sts_overrun,
    output logic [CNT_WIDTH-1:0] sts_sample_count,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        REG_FWD  = 2'd2,
        REG_WAIT = 2'd3
    } state_t;

    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] MIN_P     = CNT_WIDTH'(MIN_PERIOD);
    localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
    localparam logic [GW-1:0]        GUARD_MAX = GW'(GUARD_CYCLES - 1);

    state_t               state_q, state_d;
    logic                 run_q, run_d;
    logic                 running_q, running_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] reload_q, reload_d;
    logic [CNT_WIDTH-1:0] num_q, num_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 trigger_q, trigger_d;
    logic                 done_q, done_d;
    logic                 overrun_q, overrun_d;
    logic [31:0]          mdata_q, mdata_d;
    logic                 mvalid_q, mvalid_d;
    logic [GW-1:0]        guard_q, guard_d;
    logic                 seen_q, seen_d;

    logic                 start_ok;
    logic                 tick;
    logic                 s_ready;
    logic                 accept;
    logic [CNT_WIDTH-1:0] eff_reload;

    // A start from IDLE issues the first trigger right away, so it blocks the
    // register path exactly like a period tick does.
    assign start_ok   = (state_q == IDLE) && start && !stop;
    assign tick       = run_q && (cnt_q == '0);
    assign eff_reload = ((cfg_period < MIN_P) ? MIN_P : cfg_period) - ONE;
    assign s_ready    = !mvalid_q && !adc_busy && !tick && !start_ok &&
                        ((state_q == IDLE) || (state_q == RUN));
    assign accept     = s_ready && s_axis_tvalid;

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        running_d = running_q;
        cnt_d     = cnt_q;
        reload_d  = reload_q;
        num_d     = num_q;
        count_d   = count_q;
        trigger_d = 1'b0;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        mdata_d   = mdata_q;
        mvalid_d  = mvalid_q;
        guard_d   = guard_q;
        seen_d    = seen_q;

        // sts_running stays up through the cycle carrying the final trigger.
        if (done_q) begin
            running_d = 1'b0;
        end
        // The period counter free-runs during register forwarding to stay phase-locked.
        if (run_q) begin
            cnt_d = tick ? reload_q : cnt_q - ONE;
        end
        if (run_q && stop) begin
            run_d     = 1'b0;
            running_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    num_d     = cfg_num_samples;
                    reload_d  = eff_reload;
                    cnt_d     = eff_reload;
                    count_d   = '0;
                    overrun_d = 1'b0;
                    run_d     = 1'b1;
                    running_d = 1'b1;
                    state_d   = RUN;
                    if (adc_busy) begin
                        overrun_d = 1'b1;
                    end else begin
                        trigger_d = 1'b1;
                        count_d   = ONE;
                        if (cfg_num_samples == ONE) begin
                            done_d  = 1'b1;
                            run_d   = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end else if (accept) begin
                    mdata_d  = s_axis_tdata;
                    mvalid_d = 1'b1;
                    state_d  = REG_FWD;
                end
            end
            RUN: begin
                if (accept) begin
                    mdata_d  = s_axis_tdata;
                    mvalid_d = 1'b1;
                    state_d  = REG_FWD;
                end else if (stop) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (adc_busy) begin
                        overrun_d = 1'b1;
                    end else begin
                        trigger_d = 1'b1;
                        count_d   = count_q + ONE;
                        if ((num_q != '0) && (count_q + ONE == num_q)) begin
                            done_d  = 1'b1;
                            run_d   = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            REG_FWD: begin
                if (tick && !stop) begin
                    overrun_d = 1'b1;
                end
                if (mvalid_q && m_axis_tready) begin
                    mvalid_d = 1'b0;
                    guard_d  = '0;
                    seen_d   = 1'b0;
                    state_d  = REG_WAIT;
                end
            end
            REG_WAIT: begin
                if (tick && !stop) begin
                    overrun_d = 1'b1;
                end
                guard_d = guard_q + GW'(1);
                if (adc_busy) begin
                    seen_d = 1'b1;
                end
                // Leave on the busy falling edge, or give up if busy never rose.
                if (!adc_busy && (seen_q || (guard_q == GUARD_MAX))) begin
                    state_d = run_d ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            run_q     <= 1'b0;
            running_q <= 1'b0;
            cnt_q     <= '0;
            reload_q  <= '0;
            num_q     <= '0;
            count_q   <= '0;
            trigger_q <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            mdata_q   <= '0;
            mvalid_q  <= 1'b0;
            guard_q   <= '0;
            seen_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            running_q <= running_d;
            cnt_q     <= cnt_d;
            reload_q  <= reload_d;
            num_q     <= num_d;
            count_q   <= count_d;
            trigger_q <= trigger_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            mdata_q   <= mdata_d;
            mvalid_q  <= mvalid_d;
            guard_q   <= guard_d;
            seen_q    <= seen_d;
        end
    end

    assign trigger          = trigger_q;
    assign s_axis_tready    = s_ready;
    assign m_axis_tdata     = mdata_q;
    assign m_axis_tvalid    = mvalid_q;
    assign sts_running      = running_q;
    assign sts_done         = done_q;
    assign sts_overrun      = overrun_q;
    assign sts_sample_count = count_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_adc_acq_controller.sv
// Directed bench for adc_acq_controller: trigger schedule, clamp, register
// arbitration, overrun, guard timeout, stop/start and reset behaviour.
module tb_adc_acq_controller;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FWD  = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] cfg_period = '0;
  logic [31:0] cfg_num_samples = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        adc_busy = 1'b0;
  logic        trigger;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        sts_running;
  logic        sts_done;
  logic        sts_overrun;
  logic [31:0] sts_sample_count;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  int off = 0;
  int trig_cnt = 0;
  int trig_pos[$];
  int exp_pos[$];
  int done_pos;

  adc_acq_controller dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_period(cfg_period), .cfg_num_samples(cfg_num_samples),
    .start(start), .stop(stop), .adc_busy(adc_busy), .trigger(trigger),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .sts_running(sts_running), .sts_done(sts_done), .sts_overrun(sts_overrun),
    .sts_sample_count(sts_sample_count), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks: inputs change and outputs are sampled 1 ns after the rising edge
  task automatic step();
    @(posedge aclk);
    #1;
    off++;
    if (trigger) begin
      trig_cnt++;
      trig_pos.push_back(off);
    end
  endtask

  task automatic run_to(input int target);
    while (off < target) step();
  endtask

  task automatic do_start(input logic [31:0] p, input logic [31:0] n);
    cfg_period = p;
    cfg_num_samples = n;
    trig_pos.delete();
    trig_cnt = 0;
    off = 0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({trigger, m_axis_tvalid, sts_running, sts_done, sts_overrun} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000",
        {trigger, m_axis_tvalid, sts_running, sts_done, sts_overrun});
    end
    n_checks++;
    if (m_axis_tdata !== 32'h0 || sts_sample_count !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: tdata=%h count=%0d expected 0/0", m_axis_tdata, sts_sample_count);
    end
    n_checks++;
    if (dbg_state !== S_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE);
    end
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_period_count();
    done_pos = -1;
    do_start(32'd50, 32'd3);
    if (sts_done) done_pos = off;
    while (off < 110) begin
      step();
      if (sts_done) done_pos = off;
      if (off == 101) begin
        n_checks++;
        if (sts_running !== 1'b1) begin
          n_fail++; $display("FAIL period_running_last: got %b expected 1", sts_running);
        end
      end
      if (off == 102) begin
        n_checks++;
        if (sts_running !== 1'b0) begin
          n_fail++; $display("FAIL period_running_end: got %b expected 0", sts_running);
        end
      end
    end
    exp_pos = '{1, 51, 101};
    n_checks++;
    if (trig_pos !== exp_pos) begin
      n_fail++; $display("FAIL period_triggers: got %p expected %p", trig_pos, exp_pos);
    end
    n_checks++;
    if (done_pos !== 101) begin
      n_fail++; $display("FAIL period_done: got offset %0d expected 101", done_pos);
    end
    n_checks++;
    if (sts_sample_count !== 32'd3 || sts_overrun !== 1'b0) begin
      n_fail++; $display("FAIL period_status: count=%0d overrun=%b expected 3/0", sts_sample_count, sts_overrun);
    end
  endtask

  task automatic test_clamp();
    do_start(32'd5, 32'd3);
    run_to(90);
    exp_pos = '{1, 41, 81};
    n_checks++;
    if (trig_pos !== exp_pos) begin
      n_fail++; $display("FAIL clamp_triggers: got %p expected %p", trig_pos, exp_pos);
    end
    n_checks++;
    if (dbg_state !== S_IDLE) begin
      n_fail++; $display("FAIL clamp_state: got %0d expected %0d", dbg_state, S_IDLE);
    end
  endtask

  task automatic test_reg_arbitration();
    do_start(32'd100, 32'd0);
    run_to(31);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 32'h00A0_1401;
    n_checks++;
    if (s_axis_tready !== 1'b1) begin
      n_fail++; $display("FAIL arb_tready: got %b expected 1", s_axis_tready);
    end
    run_to(32);
    s_axis_tvalid = 1'b0;
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h00A0_1401 || dbg_state !== S_FWD) begin
      n_fail++; $display("FAIL arb_forward: valid=%b data=%h state=%0d expected 1/00a01401/%0d",
        m_axis_tvalid, m_axis_tdata, dbg_state, S_FWD);
    end
    m_axis_tready = 1'b1;
    run_to(33);
    m_axis_tready = 1'b0;
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || dbg_state !== S_WAIT) begin
      n_fail++; $display("FAIL arb_handoff: valid=%b state=%0d expected 0/%0d", m_axis_tvalid, dbg_state, S_WAIT);
    end
    adc_busy = 1'b1;
    run_to(63);
    adc_busy = 1'b0;
    run_to(65);
    n_checks++;
    if (dbg_state !== S_RUN) begin
      n_fail++; $display("FAIL arb_return: got state %0d expected %0d", dbg_state, S_RUN);
    end
    run_to(101);
    exp_pos = '{1, 101};
    n_checks++;
    if (trig_pos !== exp_pos) begin
      n_fail++; $display("FAIL arb_triggers: got %p expected %p", trig_pos, exp_pos);
    end
    n_checks++;
    if (sts_sample_count !== 32'd2 || sts_overrun !== 1'b0) begin
      n_fail++; $display("FAIL arb_status: count=%0d overrun=%b expected 2/0", sts_sample_count, sts_overrun);
    end
    do_stop();
    n_checks++;
    if (sts_running !== 1'b0 || dbg_state !== S_IDLE) begin
      n_fail++; $display("FAIL arb_stop: running=%b state=%0d expected 0/%0d", sts_running, dbg_state, S_IDLE);
    end
  endtask

  task automatic test_overrun();
    do_start(32'd40, 32'd0);
    run_to(38);
    adc_busy = 1'b1;
    run_to(42);
    adc_busy = 1'b0;
    n_checks++;
    if (trig_cnt !== 1 || sts_overrun !== 1'b1 || sts_sample_count !== 32'd1) begin
      n_fail++; $display("FAIL overrun_drop: triggers=%0d overrun=%b count=%0d expected 1/1/1",
        trig_cnt, sts_overrun, sts_sample_count);
    end
    run_to(81);
    n_checks++;
    if (trigger !== 1'b1 || sts_overrun !== 1'b1 || sts_sample_count !== 32'd2) begin
      n_fail++; $display("FAIL overrun_sticky: trigger=%b overrun=%b count=%0d expected 1/1/2",
        trigger, sts_overrun, sts_sample_count);
    end
    do_stop();
    step();
    do_start(32'd40, 32'd0);
    n_checks++;
    if (sts_overrun !== 1'b0 || sts_sample_count !== 32'd1 || trigger !== 1'b1) begin
      n_fail++; $display("FAIL overrun_clear: overrun=%b count=%0d trigger=%b expected 0/1/1",
        sts_overrun, sts_sample_count, trigger);
    end
    do_stop();
  endtask

  task automatic test_guard_timeout();
    do_start(32'd200, 32'd0);
    run_to(10);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 32'h1234_5678;
    m_axis_tready = 1'b1;
    run_to(11);
    s_axis_tvalid = 1'b0;
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL guard_forward: valid=%b data=%h expected 1/12345678", m_axis_tvalid, m_axis_tdata);
    end
    run_to(75);
    m_axis_tready = 1'b0;
    n_checks++;
    if (dbg_state !== S_WAIT) begin
      n_fail++; $display("FAIL guard_still_waiting: got state %0d expected %0d", dbg_state, S_WAIT);
    end
    run_to(76);
    n_checks++;
    if (dbg_state !== S_RUN) begin
      n_fail++; $display("FAIL guard_exit: got state %0d expected %0d", dbg_state, S_RUN);
    end
    run_to(201);
    exp_pos = '{1, 201};
    n_checks++;
    if (trig_pos !== exp_pos || sts_overrun !== 1'b0) begin
      n_fail++; $display("FAIL guard_resume: triggers=%p overrun=%b expected %p/0", trig_pos, sts_overrun, exp_pos);
    end
    do_stop();
  endtask

  task automatic test_tick_collision();
    do_start(32'd40, 32'd0);
    run_to(40);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 32'hCAFE_0001;
    n_checks++;
    if (s_axis_tready !== 1'b0) begin
      n_fail++; $display("FAIL collide_tready_tick: got %b expected 0", s_axis_tready);
    end
    run_to(41);
    n_checks++;
    if (trigger !== 1'b1 || s_axis_tready !== 1'b1) begin
      n_fail++; $display("FAIL collide_after_tick: trigger=%b tready=%b expected 1/1", trigger, s_axis_tready);
    end
    run_to(42);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    run_to(43);
    m_axis_tready = 1'b0;
    run_to(81);
    n_checks++;
    if (trigger !== 1'b0 || sts_overrun !== 1'b1 || sts_sample_count !== 32'd2) begin
      n_fail++; $display("FAIL collide_reg_tick: trigger=%b overrun=%b count=%0d expected 0/1/2",
        trigger, sts_overrun, sts_sample_count);
    end
    do_stop();
    n_checks++;
    if (sts_running !== 1'b0 || dbg_state !== S_WAIT) begin
      n_fail++; $display("FAIL collide_stop_wait: running=%b state=%0d expected 0/%0d", sts_running, dbg_state, S_WAIT);
    end
    run_to(110);
    n_checks++;
    if (dbg_state !== S_IDLE || trig_cnt !== 2) begin
      n_fail++; $display("FAIL collide_final: state=%0d triggers=%0d expected %0d/2", dbg_state, trig_cnt, S_IDLE);
    end
  endtask

  task automatic test_stop_start_same();
    cfg_period = 32'd50;
    cfg_num_samples = 32'd2;
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    n_checks++;
    if (sts_running !== 1'b0 || trigger !== 1'b0 || dbg_state !== S_IDLE) begin
      n_fail++; $display("FAIL stop_wins: running=%b trigger=%b state=%0d expected 0/0/%0d",
        sts_running, trigger, dbg_state, S_IDLE);
    end
  endtask

  task automatic test_reset_mid_fwd();
    do_start(32'd100, 32'd0);
    run_to(5);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 32'hDEAD_BEEF;
    run_to(6);
    s_axis_tvalid = 1'b0;
    n_checks++;
    if (dbg_state !== S_FWD || m_axis_tvalid !== 1'b1) begin
      n_fail++; $display("FAIL rst_fwd_setup: state=%0d valid=%b expected %0d/1", dbg_state, m_axis_tvalid, S_FWD);
    end
    aresetn = 1'b0;
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || trigger !== 1'b0 || dbg_state !== S_IDLE ||
        sts_running !== 1'b0 || m_axis_tdata !== 32'h0 || sts_sample_count !== 32'h0) begin
      n_fail++; $display("FAIL rst_fwd_async: valid=%b trigger=%b state=%0d running=%b data=%h count=%0d expected all 0",
        m_axis_tvalid, trigger, dbg_state, sts_running, m_axis_tdata, sts_sample_count);
    end
    step();
    aresetn = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_period_count();
    step();
    test_clamp();
    step();
    test_reg_arbitration();
    step();
    test_overrun();
    step();
    test_guard_timeout();
    step();
    test_tick_collision();
    step();
    test_stop_start_same();
    test_reset_mid_fwd();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_acq_controller.md
# adc_acq_controller

Sequencer in front of the SPI ADC streaming interface. Generates the periodic conversion `trigger` pulses for a programmed number of samples. Shares the ADC between conversions and register-access words from the PS-side AXI Stream, so a register word is never forwarded while a conversion is in flight or about to be triggered. Tick collisions are reported as sticky overruns.

## Interface
- `CNT_WIDTH`, 32: width of period and sample counters.
- `MIN_PERIOD`, 40: smallest effective trigger period in aclk cycles; smaller `cfg_period` values are clamped to this.
- `GUARD_CYCLES`, 64: max cycles to wait for the ADC busy flag after forwarding a register word.
- `aclk`  in  1  sole clock.
- `aresetn`  in  1  asynchronous, active-low reset.
- `cfg_period`  in  CNT_WIDTH  trigger period in aclk cycles, sampled at start.
- `cfg_num_samples`  in  CNT_WIDTH  triggers per run, sampled at start; 0 = continuous.
- `start`  in  1  single-cycle run request.
- `stop`  in  1  single-cycle abort request.
- `adc_busy`  in  1  ADC transaction in progress (inverted ADC chip-select).
- `trigger`  out  1  one-cycle conversion trigger to the ADC.
- `s_axis_tdata`  in  32  register word from the PS.
- `s_axis_tvalid`  in  1  register word valid.
- `s_axis_tready`  out  1  register word accepted.
- `m_axis_tdata`  out  32  register word to the ADC.
- `m_axis_tvalid`  out  1  register word valid toward the ADC.
- `m_axis_tready`  in  1  ADC accepts the register word.
- `sts_running`  out  1  high while in a run.
- `sts_done`  out  1  one-cycle pulse when a finite run completes.
- `sts_overrun`  out  1  sticky; a period tick was dropped.
- `sts_sample_count`  out  CNT_WIDTH  triggers issued in the current or last run.

## Operation
- Reset values: all outputs 0, including `m_axis_tdata`. State is IDLE and counters are 0.
- Period counter:
  - Loaded with `max(cfg_period, MIN_PERIOD) - 1` at start and on every tick.
  - Decrements each cycle while running.
  - A tick occurs when the counter equals 0.
- Run states: IDLE, RUN, REG_FWD, REG_WAIT.
- IDLE:
  - `start` latches config, clears `sts_sample_count` and `sts_overrun`, and moves to RUN.
  - `stop` is ignored.
- RUN:
  - On a tick with `adc_busy` low, assert `trigger` and increment `sts_sample_count`.
  - On a tick with `adc_busy` high, drop the trigger and set `sts_overrun`.
  - When a finite run's count reaches `cfg_num_samples`, go to IDLE and pulse `sts_done` in the same cycle as the final `trigger`.
- Register path:
  - `s_axis_tready` = ~`m_axis_tvalid` & ~`adc_busy` & (state in {IDLE, RUN}) & ~(tick this cycle).
  - On accept, register the word into `m_axis_tdata`, set `m_axis_tvalid`, and move to REG_FWD.
  - Any run state is remembered so the controller returns to it.
- REG_FWD: hold the word until `m_axis_tvalid & m_axis_tready`, then clear `m_axis_tvalid` and move to REG_WAIT.
- REG_WAIT:
  - Wait for `adc_busy` to rise then fall.
  - If `adc_busy` has not risen within GUARD_CYCLES, leave anyway.
  - Return to RUN if running, else IDLE.
- Ticks during REG_FWD/REG_WAIT are dropped, set `sts_overrun`, and do not advance the sample count. The period counter keeps running, so the schedule stays phase-locked.
- `stop` in any running state:
  - Clears `sts_running` next cycle; no further triggers.
  - A pending register word still completes REG_FWD/REG_WAIT, then the controller goes to IDLE.
  - No `sts_done`.
- `start` and `stop` in the same cycle: stop wins, so a start from IDLE is ignored. `start` while running is ignored.
- Reset mid-operation returns everything to reset values immediately. A half-forwarded register word is discarded.

## Timing
- `start` sampled at edge N: `sts_running` is high from N+1 and the first `trigger` pulses at N+1. Subsequent triggers follow every effective period.
- `trigger` is exactly one cycle wide and never high in two consecutive cycles.
- Register word: accepted at edge M, `m_axis_tvalid` high from M+1. Zero-bubble handoff: `m_axis_tready` high at M+1 completes at M+1.
- `sts_sample_count` updates in the same cycle as `trigger`.
- Tick and `s_axis_tvalid` in the same cycle: the tick wins and the word waits (tready low).

## Test plan
- Period and count: period=50, num=3, start at cycle 10 -> triggers at 11, 61, 111; `sts_done` at 111; `sts_running` low at 112; count=3; overrun=0.
- Clamp: period=5 -> triggers spaced 40 cycles apart.
- Register arbitration: during a run with period=100, word 0x00A01401 arrives 30 cycles after a trigger while `adc_busy` is low. The word is forwarded, the bench models `adc_busy` high for 30 cycles, and the next trigger lands on its original tick.
- Overrun: hold `adc_busy` high across a tick -> no trigger, `sts_overrun`=1 and stays set, count not incremented. A new `start` clears it.
- Guard timeout: forward a word with `adc_busy` never asserting -> controller leaves REG_WAIT after 64 cycles and triggers resume.
- Stop/reset: `stop` and `start` in the same cycle from IDLE -> stays IDLE. `aresetn` low mid-REG_FWD -> `m_axis_tvalid`=0 and `trigger`=0 immediately, state IDLE.
